// File: rtl/fpga_clk_div_seq.sv
// PLL-lock filter / sequenced reset release plus NUM_CH phase-aligned clock-enable dividers.
// Everything runs on fclk; all outputs come straight from flops.
module fpga_clk_div_seq #(
   parameter int NUM_PLL     = 2,
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                    fclk,
   input  logic                    reset_n,
   input  logic [NUM_PLL-1:0]      pll_locked,
   input  logic [NUM_CH*DIV_W-1:0] div_ratio,
   input  logic                    cfg_load,
   input  logic [NUM_CH-1:0]       ch_en,
   output logic                    sys_rst_n,
   output logic                    locked_all,
   output logic [7:0]              lock_loss_cnt,
   output logic [NUM_CH-1:0]       clk_en,
   output logic [NUM_CH-1:0]       clk_div
);

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_FILT = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [15:0]      LOCK_TGT = 16'(LOCK_CYCLES);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);

   state_t                         state_q, state_d;
   logic [NUM_PLL-1:0]             sync1_q, sync1_d;
   logic [NUM_PLL-1:0]             sync2_q, sync2_d;
   logic [15:0]                    filt_cnt_q, filt_cnt_d;
   logic [7:0]                     loss_q, loss_d;
   logic                           run_q, run_d;
   logic [NUM_CH-1:0][DIV_W-1:0]   shadow_q, shadow_d;
   logic [NUM_CH-1:0][DIV_W-1:0]   cnt_q, cnt_d;
   logic [NUM_CH-1:0]              act_q, act_d;
   logic [NUM_CH-1:0]              en_q, en_d;
   logic [NUM_CH-1:0]              div_q, div_d;
   logic                           lk;
   logic                           realign;
   logic [15:0]                    filt_inc;

   assign sync1_d = pll_locked;
   assign sync2_d = sync1_q;
   assign lk      = &sync2_q;

   // Lock FSM: FILT needs LOCK_CYCLES unbroken lk cycles before RUN is entered.
   always_comb begin
      state_d    = state_q;
      filt_cnt_d = filt_cnt_q;
      loss_d     = loss_q;
      filt_inc   = filt_cnt_q + 16'd1;
      case (state_q)
         ST_WAIT: begin
            filt_cnt_d = '0;
            if (lk) state_d = ST_FILT;
         end
         ST_FILT: begin
            if (!lk) begin
               state_d    = ST_WAIT;
               filt_cnt_d = '0;
            end else begin
               filt_cnt_d = filt_inc;
               if (filt_inc == LOCK_TGT) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            filt_cnt_d = '0;
            if (!lk) begin
               state_d = ST_WAIT;
               if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
            end
         end
         default: begin
            state_d    = ST_WAIT;
            filt_cnt_d = '0;
         end
      endcase
   end

   assign run_d   = (state_d == ST_RUN);
   assign realign = (state_q == ST_RUN) && cfg_load;

   // Outputs are decoded from the next count and the next shadow so they land registered.
   always_comb begin
      logic [DIV_W-1:0] n_cur, nm1_cur, n_nxt, nm1_nxt, half_nxt;
      n_cur    = '0;
      nm1_cur  = '0;
      n_nxt    = '0;
      nm1_nxt  = '0;
      half_nxt = '0;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      act_d    = '0;
      en_d     = '0;
      div_d    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_load) shadow_d[i] = div_ratio[i*DIV_W +: DIV_W];
         n_cur    = (shadow_q[i] == '0) ? DIV_ONE : shadow_q[i];
         nm1_cur  = n_cur - DIV_ONE;
         n_nxt    = (shadow_d[i] == '0) ? DIV_ONE : shadow_d[i];
         nm1_nxt  = n_nxt - DIV_ONE;
         half_nxt = n_nxt - (n_nxt >> 1);
         act_d[i] = run_d && ch_en[i];
         if (!act_d[i] || !act_q[i] || realign || (cnt_q[i] >= nm1_cur))
            cnt_d[i] = '0;
         else
            cnt_d[i] = cnt_q[i] + DIV_ONE;
         en_d[i]  = act_d[i] && (cnt_d[i] == nm1_nxt);
         div_d[i] = act_d[i] && (cnt_d[i] < half_nxt);
      end
   end

   always_ff @(posedge fclk) begin
      if (!reset_n) begin
         state_q    <= ST_WAIT;
         sync1_q    <= '0;
         sync2_q    <= '0;
         filt_cnt_q <= '0;
         loss_q     <= '0;
         run_q      <= 1'b0;
         cnt_q      <= '0;
         act_q      <= '0;
         en_q       <= '0;
         div_q      <= '0;
         for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= DIV_RST;
      end else begin
         state_q    <= state_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         filt_cnt_q <= filt_cnt_d;
         loss_q     <= loss_d;
         run_q      <= run_d;
         cnt_q      <= cnt_d;
         act_q      <= act_d;
         en_q       <= en_d;
         div_q      <= div_d;
         shadow_q   <= shadow_d;
      end
   end

   assign sys_rst_n     = run_q;
   assign locked_all    = run_q;
   assign lock_loss_cnt = loss_q;
   assign clk_en        = en_q;
   assign clk_div       = div_q;

endmodule

// File: tb/tb_fpga_clk_div_seq.sv
// Cycle-exact bench for fpga_clk_div_seq: expected outputs are queued per driven cycle
// from the timing rules of the block and compared on the falling edge.
module tb_fpga_clk_div_seq;

   localparam int NUM_PLL     = 2;
   localparam int NUM_CH      = 4;
   localparam int DIV_W       = 8;
   localparam int DEFAULT_DIV = 2;
   localparam int LOCK_CYCLES = 16;
   localparam int EW          = 18;

   logic                    fclk = 1'b0;
   logic                    reset_n;
   logic [NUM_PLL-1:0]      pll_locked;
   logic [NUM_CH*DIV_W-1:0] div_ratio;
   logic                    cfg_load;
   logic [NUM_CH-1:0]       ch_en;
   logic                    sys_rst_n;
   logic                    locked_all;
   logic [7:0]              lock_loss_cnt;
   logic [NUM_CH-1:0]       clk_en;
   logic [NUM_CH-1:0]       clk_div;

   fpga_clk_div_seq #(
      .NUM_PLL(NUM_PLL), .NUM_CH(NUM_CH), .DIV_W(DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV), .LOCK_CYCLES(LOCK_CYCLES)
   ) dut (
      .fclk(fclk), .reset_n(reset_n), .pll_locked(pll_locked), .div_ratio(div_ratio),
      .cfg_load(cfg_load), .ch_en(ch_en), .sys_rst_n(sys_rst_n), .locked_all(locked_all),
      .lock_loss_cnt(lock_loss_cnt), .clk_en(clk_en), .clk_div(clk_div)
   );

   // ---------------- clock ----------------
   always #5 fclk = ~fclk;

   // ---------------- scoreboard state ----------------
   int              n_checks = 0;
   int              n_fail   = 0;
   int              cyc      = 0;
   logic [EW-1:0]   exp_q[$];
   string           tag_q[$];
   string           phase = "reset";

   bit              e_run;
   int              e_loss;
   int              e_n[NUM_CH];
   int              e_base[NUM_CH];
   bit              e_act[NUM_CH];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int eff_ratio(input logic [DIV_W-1:0] r);
      return (r == 0) ? 1 : int'(r);
   endfunction

   // Expected outputs for the current cycle from the local-cycle definition.
   function automatic logic [EW-1:0] exp_vec();
      logic [3:0] en;
      logic [3:0] dv;
      en = '0;
      dv = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (e_run && e_act[i]) begin
            int c;
            c     = (cyc - e_base[i]) % e_n[i];
            en[i] = (c == e_n[i] - 1);
            dv[i] = (c < (e_n[i] + 1) / 2);
         end
      end
      return {e_run, e_run, 8'(e_loss), en, dv};
   endfunction

   always @(negedge fclk) begin
      if (exp_q.size() != 0) begin
         logic [EW-1:0] e;
         string         t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check_val({t, ":sys_rst_n"},  sys_rst_n,     e[17]);
         check_val({t, ":locked_all"}, locked_all,    e[16]);
         check_val({t, ":loss_cnt"},   lock_loss_cnt, e[15:8]);
         check_val({t, ":clk_en"},     clk_en,        e[7:4]);
         check_val({t, ":clk_div"},    clk_div,       e[3:0]);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge fclk);
      #1;
      cyc++;
      exp_q.push_back(exp_vec());
      tag_q.push_back(phase);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic inc_loss();
      e_loss = (e_loss < 255) ? e_loss + 1 : 255;
   endtask

   // Next cycle is the first RUN cycle.
   task automatic relock_expect();
      e_run = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         e_base[i] = cyc + 1;
         e_act[i]  = ch_en[i];
      end
   endtask

   task automatic load_cfg(input logic [31:0] r);
      div_ratio = r;
      cfg_load  = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         e_n[i] = eff_ratio(r[i*DIV_W +: DIV_W]);
         if (e_run) e_base[i] = cyc + 1;
      end
      step();
      cfg_load = 1'b0;
   endtask

   task automatic set_en(input logic [3:0] v);
      for (int i = 0; i < NUM_CH; i++) begin
         if (v[i] && !e_act[i]) e_base[i] = cyc + 1;
         e_act[i] = v[i];
      end
      ch_en = v;
   endtask

   // One-cycle drop of pll_locked[b] in RUN followed by the quickest relock.
   task automatic lose_and_relock(input int b);
      pll_locked[b] = 1'b0;
      step();
      pll_locked = 2'b11;
      step();
      e_run = 1'b0;
      inc_loss();
      step();
      run(LOCK_CYCLES);
      relock_expect();
      step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n    = 1'b0;
      pll_locked = '0;
      div_ratio  = '0;
      cfg_load   = 1'b0;
      ch_en      = 4'hF;
      e_run      = 1'b0;
      e_loss     = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         e_n[i]    = DEFAULT_DIV;
         e_base[i] = 0;
         e_act[i]  = 1'b0;
      end

      phase = "reset";
      run(3);
      reset_n = 1'b1;
      phase = "cfg_wait";
      load_cfg({8'd8, 8'd3, 8'd2, 8'd1});
      run(3);

      phase = "lock_release";
      pll_locked = 2'b11;
      run(LOCK_CYCLES + 2);
      relock_expect();
      phase = "div_pattern";
      step();
      run(47);

      phase = "ratio0";
      load_cfg({8'd8, 8'd3, 8'd2, 8'd0});
      run(12);

      phase = "realign";
      load_cfg({8'd8, 8'd3, 8'd2, 8'd4});
      run(7 + $urandom_range(0, 6));
      load_cfg({8'd8, 8'd3, 8'd2, 8'd5});
      run(20);

      phase = "ch_en";
      set_en(4'b1011);
      run(5);
      set_en(4'b1111);
      run(10);
      set_en(4'b0000);
      run(3);
      set_en(4'b1111);
      run(10);

      phase = "lock_loss";
      lose_and_relock(0);
      run(10);

      // Glitch on pll_locked[1] ten cycles after relock starts restarts the filter.
      phase = "filt_glitch";
      pll_locked[0] = 1'b0;
      step();
      pll_locked = 2'b11;
      step();
      e_run = 1'b0;
      inc_loss();
      step();
      run(8);
      pll_locked[1] = 1'b0;
      step();
      pll_locked = 2'b11;
      run(LOCK_CYCLES + 2);
      relock_expect();
      step();
      run(10);

      phase = "cfg_at_loss";
      pll_locked[1] = 1'b0;
      step();
      pll_locked = 2'b11;
      step();
      div_ratio = {8'd3, 8'd2, 8'd2, 8'd2};
      cfg_load  = 1'b1;
      for (int i = 0; i < NUM_CH; i++) e_n[i] = eff_ratio(div_ratio[i*DIV_W +: DIV_W]);
      e_run = 1'b0;
      inc_loss();
      step();
      cfg_load = 1'b0;
      run(LOCK_CYCLES);
      relock_expect();
      step();
      run(24);

      phase = "mid_reset";
      reset_n = 1'b0;
      e_run   = 1'b0;
      e_loss  = 0;
      for (int i = 0; i < NUM_CH; i++) e_n[i] = DEFAULT_DIV;
      step();
      run(2);
      reset_n = 1'b1;
      run(LOCK_CYCLES + 2);
      relock_expect();
      step();
      run(12);

      phase = "saturate";
      for (int k = 0; k < 256; k++) begin
         lose_and_relock($urandom_range(0, 1));
         run($urandom_range(1, 3));
      end
      @(negedge fclk);
      check_val("loss_saturated", lock_loss_cnt, 32'd255);

      phase = "final_reset";
      reset_n = 1'b0;
      e_run   = 1'b0;
      e_loss  = 0;
      for (int i = 0; i < NUM_CH; i++) e_n[i] = DEFAULT_DIV;
      step();
      run(2);
      @(negedge fclk);
      #1;
      check_val("queue_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fpga_clk_div_seq.md
# fpga_clk_div_seq

Parametrised clock-enable generator and PLL-lock reset sequencer for the V2M-MPS2 FPGA clocking path. It sits downstream of the PLL wrapper, on the free-running `fclk` domain. It filters the PLL `locked` indications and releases a sequenced system reset. It generates `NUM_CH` programmable, phase-aligned divided enables and divided waveforms, replacing fixed PLL output taps for low-rate peripheral and audio timing.

## Interface
- `NUM_PLL`, 2, number of PLL lock inputs monitored
- `NUM_CH`, 4, number of divider channels
- `DIV_W`, 8, width of each divide ratio
- `DEFAULT_DIV`, 2, divide ratio loaded into every channel at reset
- `LOCK_CYCLES`, 16, consecutive all-locked cycles required before reset release (1..2^16-1)

Ports:
- `fclk`  in  1  single clock for the whole block
- `reset_n`  in  1  synchronous, active-low reset
- `pll_locked`  in  `NUM_PLL`  PLL lock flags, asynchronous to `fclk`
- `div_ratio`  in  `NUM_CH*DIV_W`  per-channel divide ratio N; channel i uses bits [i*DIV_W +: DIV_W]
- `cfg_load`  in  1  single-cycle strobe that loads `div_ratio` and realigns all channels
- `ch_en`  in  `NUM_CH`  per-channel run enable
- `sys_rst_n`  out  1  sequenced active-low system reset
- `locked_all`  out  1  high while the state is RUN
- `lock_loss_cnt`  out  8  saturating count of lock losses seen in RUN
- `clk_en`  out  `NUM_CH`  one-cycle enable pulse every N cycles
- `clk_div`  out  `NUM_CH`  divided waveform of period N

## Operation
- `pll_locked` passes through a 2-flop synchroniser per bit. `lk` is the AND of the synchronised bits.
- Lock FSM states:
  - WAIT: `sys_rst_n`=0. Moves to FILT when `lk`=1.
  - FILT: a 16-bit counter counts `lk` cycles. Returns to WAIT, with the counter cleared, if `lk`=0. Moves to RUN when the counter reaches `LOCK_CYCLES`.
  - RUN: `sys_rst_n`=1 and `locked_all`=1. Moves to WAIT when `lk`=0, and `lock_loss_cnt` increments, saturating at 255.
- Reset places the FSM in WAIT.
- Shadow ratios: `NUM_CH` registers, each loaded with `DEFAULT_DIV` on reset.
  - When `cfg_load` is high, every shadow loads from `div_ratio` in any FSM state.
  - A ratio of 0 is treated as 1.
- Channel i is active when the FSM is in RUN and `ch_en[i]`=1.
  - Active: `cnt[i]` counts 0..N-1 and wraps.
  - Inactive: `cnt[i]` is held at 0, and `clk_en[i]`=`clk_div[i]`=0.
- `cfg_load` sampled in RUN forces every counter to 0 on the next cycle, so all channels restart phase-aligned with their new ratios.
- Define local cycle c: c=0 is the first cycle an active channel has `cnt`=0 after activation, realignment or RUN entry.
  - `clk_en[i]`=1 in cycles where c mod N = N-1.
  - `clk_div[i]`=1 in cycles where c mod N < ceil(N/2).
  - Both outputs are flop-driven and decoded from the next count, with no combinational path from inputs to outputs.
- Special ratios:
  - N=1: `clk_en` and `clk_div` are constantly 1 while active.
  - N odd: `clk_div` is high for (N+1)/2 cycles and low for (N-1)/2 cycles.
- Counter widths are `DIV_W` bits. N-1 is computed in `DIV_W` bits after the 0→1 substitution, so there is no overflow at N=2^DIV_W-1.

## Timing
- Reset values: `sys_rst_n`=0, `locked_all`=0, `lock_loss_cnt`=0, `clk_en`=0, `clk_div`=0, all `cnt`=0, shadows=`DEFAULT_DIV`.
- Lock release: with all `pll_locked` high from cycle t and stable, `sys_rst_n` and `locked_all` rise at cycle t+LOCK_CYCLES+3. This is 2 synchroniser cycles plus 1 FSM cycle plus the count.
- Lock loss: a `pll_locked` bit low at cycle t causes the following at t+3:
  - `sys_rst_n`=0 and `locked_all`=0;
  - all `clk_en`/`clk_div`=0;
  - `lock_loss_cnt` incremented.
- Any `lk` low cycle in FILT restarts the full `LOCK_CYCLES` count.
- RUN entry at cycle r: channels with `ch_en`=1 have c=0 at r. `clk_div`=1 at r. `clk_en` first pulses at r+N-1.
- `cfg_load` at cycle t in RUN: new ratios take effect and c=0 at t+1 for all active channels.
- `cfg_load` coincident with lock loss: the shadows load and the FSM goes to WAIT. There is no alignment effect until the next RUN.
- `ch_en[i]` rising, sampled at cycle t: c=0 at t+1. `ch_en[i]` falling at t: outputs are 0 at t+1.
- `reset_n` low mid-operation: all state returns to reset values on the next edge, including the shadows and `lock_loss_cnt`.

## Test plan
- **Lock release:** `LOCK_CYCLES`=16, `pll_locked`=2'b11 from cycle 5 -> `sys_rst_n` and `locked_all` rise at cycle 24 and not before.
- **Filter glitch:** `pll_locked[1]` low for one cycle at cycle 15 during FILT -> count restarts; `sys_rst_n` rises 16+3 cycles after the bit returns high.
- **Divider patterns:** ratios 1, 2, 3, 8 on ch0..3, all enabled, check over 48 cycles from RUN entry ->
  - ch0: `clk_en`=1 always.
  - ch1: `clk_en` pulses on odd cycles; `clk_div` is 1,0,1,0...
  - ch2: `clk_div` is 1,1,0 repeating; `clk_en` at c=2,5,8...
  - ch3: `clk_en` at c=7,15...; `clk_div` high 4 cycles, low 4 cycles.
- **Ratio 0:** `div_ratio` ch0=0 loaded -> behaves exactly as N=1.
- **Realignment:** `cfg_load` at an arbitrary RUN cycle with ch0 changed 4->5 -> all four counters are 0 and `clk_div`=1 on the next cycle; ch0 pulses every 5 cycles after that.
- **Lock loss and saturation:** drop `pll_locked[0]` in RUN -> outputs 0 and `sys_rst_n`=0 exactly 3 cycles later, `lock_loss_cnt`=1. After 256 loss/relock cycles, `lock_loss_cnt` holds 255. `reset_n` low -> `lock_loss_cnt`=0.
